sync_fifo_wm: RTL and testbench

Parametrised single-clock FIFO with inferred storage, a registered read port, and a complete flag set: empty/full, one-from-limit, programmable watermarks, sticky overrun/underrun, and a fill level. It generalises the fabric BRAM FIFO mode to arbitrary data width and depth for soft FIFOs in the qlf_k6n10f flow. It also adds a synchronous FLUSH and an exported occupancy count.

---
 rtl/sync_fifo_wm.sv | 110 +++++++++++
 tb/tb_sync_fifo_wm.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_wm.sv
// Single-clock FIFO with inferred storage, registered read port, occupancy count,
// programmable watermarks and sticky overrun/underrun flags.
module sync_fifo_wm #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FLUSH,
  input  logic                  WEN,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  REN,
  output logic [DATA_WIDTH-1:0] RDATA,
  input  logic [ADDR_WIDTH-1:0] UPAF,
  input  logic [ADDR_WIDTH-1:0] UPAE,
  output logic [ADDR_WIDTH:0]   LEVEL,
  output logic                  EMPTY,
  output logic                  EPO,
  output logic                  EWM,
  output logic                  UNDERRUN,
  output logic                  FULL,
  output logic                  FMO,
  output logic                  FWM,
  output logic                  OVERRUN
);

  localparam int                DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LVL_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LVL_DM1   = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] LVL_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   level;
  logic                  overrun;
  logic                  underrun;
  logic [DATA_WIDTH-1:0] rdata;

  logic rd_ok;
  logic wr_ok;
  logic wr_en;
  logic rd_en;

  // A full FIFO still takes a write when the same cycle pops an entry, which keeps
  // full-rate streaming possible; an empty FIFO never forwards the incoming word.
  assign rd_ok = REN && (level != '0);
  assign wr_ok = WEN && ((level != LVL_DEPTH) || rd_ok);
  assign wr_en = wr_ok && !RST && !FLUSH;
  assign rd_en = rd_ok && !RST && !FLUSH;

  // Storage: no reset so it maps onto plain inferred RAM.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wptr] <= WDATA;
    end
  end

  // Registered read port.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[rptr];
    end
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_ok) begin
        rptr <= rptr + PTR_ONE;
      end
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      if (WEN && !wr_ok) begin
        overrun <= 1'b1;
      end
      if (REN && !rd_ok) begin
        underrun <= 1'b1;
      end
    end
  end

  // Flag decode straight off the level register; thresholds act combinationally.
  assign EMPTY    = (level == '0);
  assign EPO      = (level == LVL_ONE);
  assign EWM      = (level <= {1'b0, UPAE});
  assign FULL     = (level == LVL_DEPTH);
  assign FMO      = (level == LVL_DM1);
  assign FWM      = ((LVL_DEPTH - level) <= {1'b0, UPAF});
  assign LEVEL    = level;
  assign RDATA    = rdata;
  assign OVERRUN  = overrun;
  assign UNDERRUN = underrun;

endmodule

// File: tb/tb_sync_fifo_wm.sv
// Directed self-checking bench for sync_fifo_wm at DATA_WIDTH=18, ADDR_WIDTH=4.
module tb_sync_fifo_wm;

  localparam int DW = 18;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, flush, wen, ren;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic [AW-1:0] upaf, upae;
  logic [AW:0]   level;
  logic          empty, epo, ewm, underrun, full, fmo, fwm, overrun;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sync_fifo_wm #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK(clk), .RST(rst), .FLUSH(flush), .WEN(wen), .WDATA(wdata), .REN(ren),
    .RDATA(rdata), .UPAF(upaf), .UPAE(upae), .LEVEL(level),
    .EMPTY(empty), .EPO(epo), .EWM(ewm), .UNDERRUN(underrun),
    .FULL(full), .FMO(fmo), .FWM(fwm), .OVERRUN(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; ren = 1'b0; flush = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1; cycle(); flush = 1'b0;
  endtask

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_rd;
  int            wcount;
  int            ph;

  initial begin
    rst = 1'b1; flush = 1'b0; wen = 1'b0; ren = 1'b0; wdata = '0;
    upaf = 4'd3; upae = 4'd2;
    cycle(); cycle();
    rst = 1'b0;
    chk("rst_rdata", rdata, 0);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_epo", epo, 0);
    chk("rst_ewm", ewm, 1);
    chk("rst_underrun", underrun, 0);
    chk("rst_full", full, 0);
    chk("rst_fmo", fmo, 0);
    chk("rst_fwm", fwm, 0);
    chk("rst_overrun", overrun, 0);

    // Fill with watermark tracking, then one overrun write.
    for (int i = 1; i <= 16; i++) begin
      wen = 1'b1; wdata = DW'(i);
      cycle();
      chk("fill_level", level, i);
      chk("fill_empty", empty, 0);
      chk("fill_epo", epo, (i == 1));
      chk("fill_ewm", ewm, (i <= 2));
      chk("fill_fwm", fwm, (i >= 13));
      chk("fill_fmo", fmo, (i == 15));
      chk("fill_full", full, (i == 16));
    end
    wdata = 18'h3FFFF;
    cycle();
    wen = 1'b0;
    chk("ovr_flag", overrun, 1);
    chk("ovr_level", level, 16);
    chk("ovr_full", full, 1);

    // Drain, then one underrun read.
    for (int i = 1; i <= 16; i++) begin
      ren = 1'b1;
      cycle();
      chk("drain_rdata", rdata, i);
      chk("drain_level", level, 16 - i);
      chk("drain_epo", epo, (i == 15));
      chk("drain_empty", empty, (i == 16));
    end
    cycle();
    ren = 1'b0;
    chk("udr_flag", underrun, 1);
    chk("udr_rdata", rdata, 18'h00010);
    chk("udr_level", level, 0);

    // Simultaneous read+write on an empty FIFO.
    do_flush();
    chk("fl0_underrun", underrun, 0);
    chk("fl0_overrun", overrun, 0);
    wen = 1'b1; ren = 1'b1; wdata = 18'h2AAAA;
    cycle();
    idle();
    chk("rw0_level", level, 1);
    chk("rw0_underrun", underrun, 1);
    chk("rw0_rdata", rdata, 18'h00010);
    ren = 1'b1;
    cycle();
    idle();
    chk("rw0_readback", rdata, 18'h2AAAA);
    chk("rw0_empty", empty, 1);

    // Simultaneous read+write on a full FIFO.
    do_flush();
    for (int i = 0; i < 16; i++) begin
      wen = 1'b1; wdata = DW'(18'h100 + i);
      cycle();
    end
    chk("rwf_full", full, 1);
    wen = 1'b1; ren = 1'b1; wdata = 18'h00200;
    cycle();
    idle();
    chk("rwf_rdata", rdata, 18'h00100);
    chk("rwf_level", level, 16);
    chk("rwf_overrun", overrun, 0);
    for (int i = 1; i <= 16; i++) begin
      ren = 1'b1;
      cycle();
      chk("rwf_drain", rdata, (i == 16) ? 32'h200 : 32'h100 + i);
    end
    idle();
    chk("rwf_empty", empty, 1);

    // Wrap-around with a queue model, level held between 5 and 6.
    wcount = 0;
    for (int i = 0; i < 5; i++) begin
      wen = 1'b1; wdata = DW'(18'h1000 + wcount);
      q.push_back(wdata); wcount++;
      cycle();
    end
    idle();
    ph = 0;
    while (wcount < 40) begin
      wen = (ph != 3);
      ren = (ph != 1);
      wdata = DW'(18'h1000 + wcount);
      if (ren) exp_rd = q.pop_front();
      if (wen) begin q.push_back(wdata); wcount++; end
      cycle();
      if (ren) chk("wrap_rdata", rdata, exp_rd);
      chk("wrap_level", level, q.size());
      chk("wrap_flags", {empty, full, overrun, underrun}, 0);
      ph = (ph + 1) % 4;
    end
    idle();
    while (q.size() > 0) begin
      ren = 1'b1;
      exp_rd = q.pop_front();
      cycle();
      chk("wrap_tail", rdata, exp_rd);
    end
    idle();
    chk("wrap_empty", empty, 1);

    // FLUSH at level 5 with overrun set, with WEN/REN asserted alongside.
    do_flush();
    for (int i = 0; i < 17; i++) begin
      wen = 1'b1; wdata = DW'(18'h20 + i);
      cycle();
    end
    idle();
    for (int i = 0; i < 11; i++) begin
      ren = 1'b1; cycle();
    end
    idle();
    chk("fl_pre_level", level, 5);
    chk("fl_pre_overrun", overrun, 1);
    chk("fl_pre_rdata", rdata, 18'h2A);
    flush = 1'b1; wen = 1'b1; ren = 1'b1; wdata = 18'h3C3C3;
    cycle();
    idle();
    chk("fl_level", level, 0);
    chk("fl_empty", empty, 1);
    chk("fl_overrun", overrun, 0);
    chk("fl_underrun", underrun, 0);
    chk("fl_rdata", rdata, 18'h2A);
    wen = 1'b1; wdata = 18'h12345;
    cycle();
    idle();
    ren = 1'b1;
    cycle();
    idle();
    chk("fl_newword", rdata, 18'h12345);
    chk("fl_post_level", level, 0);

    // Reset mid-burst discards queued data.
    for (int i = 0; i < 3; i++) begin
      wen = 1'b1; wdata = DW'(18'h500 + i);
      cycle();
    end
    rst = 1'b1; wen = 1'b0;
    cycle();
    rst = 1'b0;
    chk("mrst_level", level, 0);
    chk("mrst_rdata", rdata, 0);
    wen = 1'b1; wdata = 18'h0ABCD;
    cycle();
    idle();
    ren = 1'b1;
    cycle();
    idle();
    chk("mrst_first", rdata, 18'h0ABCD);

    // Threshold inputs act in the same cycle.
    upae = 4'd0;
    #1;
    chk("ewm_upae0", ewm, 1);
    upaf = 4'd15;
    #1;
    chk("fwm_upaf15", fwm, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
